axis_fifo_pkt: RTL
==================

Name: axis_fifo_pkt

Overview:
- Parametrised AXI-Stream synchronous FIFO for the scfifo library; next generation of the basic single-clock stream FIFO.
- Adds arbitrary (non-power-of-two) depth, TLAST/TUSER sideband, live fill level, runtime almost-full/almost-empty thresholds and a synchronous flush.
- Optional packet (store-and-forward) mode.
- Sits between stream producers/consumers wherever rate decoupling or packet-boundary buffering is needed.

Parameters:
- T_DATA_WIDTH, 32, payload width in bits.
- T_USER_WIDTH, 1, sideband width in bits, stored alongside data; minimum 1.
- DEPTH, 10, number of entries, any value >= 2; pointers wrap at DEPTH-1.
- LVL_W, $clog2(DEPTH+1), derived localparam; width of level and threshold signals.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous flush; empties FIFO in one cycle.
- s_data_i  in  T_DATA_WIDTH  input payload.
- s_user_i  in  T_USER_WIDTH  input sideband.
- s_last_i  in  1  end of packet.
- s_valid_i  in  1  input valid.
- s_ready_o  out  1  input ready.
- m_data_o  out  T_DATA_WIDTH  output payload.
- m_user_o  out  T_USER_WIDTH  output sideband.
- m_last_o  out  1  output end of packet.
- m_valid_o  out  1  output valid.
- m_ready_i  in  1  output ready.
- af_thresh_i  in  LVL_W  almost-full threshold.
- ae_thresh_i  in  LVL_W  almost-empty threshold.
- level_o  out  LVL_W  current number of stored entries.
- fifo_full_o  out  1  level_o == DEPTH.
- fifo_empty_o  out  1  level_o == 0.
- almost_full_o  out  1  level_o >= af_thresh_i.
- almost_empty_o  out  1  level_o <= ae_thresh_i.

Behaviour:
Reset (async assert, sync release):
- wr_ptr = rd_ptr = 0, level_o = 0.
- s_ready_o = 1, m_valid_o = 0, fifo_empty_o = 1, fifo_full_o = 0.
- almost_empty_o = 1; almost_full_o = (af_thresh_i == 0).
- RAM contents are not reset.

Handshakes:
- Write when s_valid_i & s_ready_o; read when m_valid_o & m_ready_i.
- s_ready_o and m_valid_o are registered. s_ready_o = !full. m_valid_o = !empty (non-packet mode).
- s_ready_o does not depend on m_ready_i, so there is no write-through when full.

Data path:
- First-word fall-through: m_data_o, m_user_o and m_last_o are read combinationally from RAM[rd_ptr].
- Write-to-visible latency is 1 cycle: a word written at edge N has m_valid_o = 1 after edge N.

Pointers:
- Increment modulo DEPTH: (DEPTH-1) -> 0 explicitly, so non-power-of-two depths are legal.

Level:
- level_next = level + write - read.
- Simultaneous read and write leaves level, full and empty unchanged.
- Full/empty derive from level_next, so there is no pointer-equality ambiguity.

Flags:
- almost_full_o and almost_empty_o are combinational compares of registered level_o against the threshold inputs.
- Thresholds may change at any time; the flags follow in the same cycle.

Flush:
- flush_i = 1 at an edge forces the reset state except RAM, and overrides any concurrent read or write.
- The write handshaked in that cycle is dropped; the producer must treat it as lost.

Boundaries:
- Read when empty or write when full cannot occur, because of the handshake gating.
- Full with m_ready_i = 1: the read frees a slot and s_ready_o rises on the next cycle.
- Empty with simultaneous write: no read that cycle; m_valid_o rises on the next cycle.

Optional Feature:
- Macro: AXIS_FIFO_PKT_MODE_EN.

Defined (store-and-forward):
- Registered pkt_cnt (LVL_W bits) counts complete packets held.
- pkt_cnt increments on a write with s_last_i = 1 and decrements on a read with m_last_o = 1; both at once leaves it unchanged.
- m_valid_o = !empty & (pkt_cnt != 0 | full).
- The full override prevents deadlock on packets longer than DEPTH; such packets pass cut-through.
- flush_i and reset clear pkt_cnt.

Undefined:
- No pkt_cnt is instantiated; m_valid_o = !empty.
- s_last_i is stored and forwarded only.

Test Plan:
1. DEPTH=5: write 5 words 0xA0..0xA4 with m_ready_i=0 -> after 5th write s_ready_o=0, fifo_full_o=1, level_o=5; then drain -> words read in order 0xA0..0xA4, fifo_empty_o=1, level_o=0.
2. DEPTH=5: continuous write+read for 12 cycles after 2-word prefill -> level_o constant 2, no drop/duplication across pointer wrap 4->0, full/empty never assert.
3. af_thresh_i=4, ae_thresh_i=1: fill 0..5 -> almost_empty_o=1 for level 0..1, almost_full_o=1 from level 4; change af_thresh_i to 5 at level 4 -> almost_full_o drops same cycle.
4. Level 3, flush_i=1 with concurrent s_valid_i=1 -> next cycle level_o=0, m_valid_o=0, s_ready_o=1; the concurrent word never appears on the output.
5. With AXIS_FIFO_PKT_MODE_EN: write 3-word packet, last on word 3 -> m_valid_o stays 0 until the cycle after word 3; 7-word packet into DEPTH=5 -> m_valid_o asserts when full, all 7 words delivered.
6. Assert reset_n low mid-stream at level 3 with m_ready_i=1 -> outputs immediately return to reset values; after release the FIFO accepts and returns a new word 0x55 with 1-cycle latency.

Source files
------------

// File: rtl/axis_fifo_pkt.sv
// axis_fifo_pkt: single-clock AXI-Stream FIFO with arbitrary depth, TLAST/TUSER
// sideband, live fill level, runtime almost-full/almost-empty thresholds and a
// synchronous flush. First-word fall-through output read straight from RAM.
// Optional store-and-forward packet mode is enabled by defining the macro
// AXIS_FIFO_PKT_MODE_EN; without it m_valid_o simply tracks "not empty".
module axis_fifo_pkt #(
    parameter int T_DATA_WIDTH = 32,
    parameter int T_USER_WIDTH = 1,
    parameter int DEPTH        = 10,
    localparam int LVL_W       = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush_i,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic [T_USER_WIDTH-1:0] s_user_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic [T_USER_WIDTH-1:0] m_user_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    input  logic [LVL_W-1:0]        af_thresh_i,
    input  logic [LVL_W-1:0]        ae_thresh_i,
    output logic [LVL_W-1:0]        level_o,
    output logic                    fifo_full_o,
    output logic                    fifo_empty_o,
    output logic                    almost_full_o,
    output logic                    almost_empty_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = T_DATA_WIDTH + T_USER_WIDTH + 1;

    logic [ENTRY_W-1:0] ram [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [LVL_W-1:0] level, level_next;
    logic             ready, valid, empty;
    logic             full_next, empty_next, valid_next;
    logic             wr, rd;

`ifdef AXIS_FIFO_PKT_MODE_EN
    logic [LVL_W-1:0] pkt_cnt, pkt_cnt_next;
`endif

    // Explicit wrap so that non-power-of-two depths are legal.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr = s_valid_i & ready;
    assign rd = valid & m_ready_i;

    assign {m_last_o, m_user_o, m_data_o} = ram[rd_ptr];

    assign s_ready_o      = ready;
    assign m_valid_o      = valid;
    assign level_o        = level;
    assign fifo_full_o    = ~ready;
    assign fifo_empty_o   = empty;
    assign almost_full_o  = (level >= af_thresh_i);
    assign almost_empty_o = (level <= ae_thresh_i);

    // Next pointers, level and handshake flags; flush overrides any transfer.
    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        level_next  = level;
        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (wr) wr_ptr_next = ptr_inc(wr_ptr);
            if (rd) rd_ptr_next = ptr_inc(rd_ptr);
            level_next = level + {{(LVL_W-1){1'b0}}, wr} - {{(LVL_W-1){1'b0}}, rd};
        end
        full_next  = (level_next == LVL_W'(DEPTH));
        empty_next = (level_next == '0);
`ifdef AXIS_FIFO_PKT_MODE_EN
        pkt_cnt_next = '0;
        if (!flush_i)
            pkt_cnt_next = pkt_cnt + {{(LVL_W-1){1'b0}}, wr & s_last_i}
                                   - {{(LVL_W-1){1'b0}}, rd & m_last_o};
        // Full override lets packets longer than DEPTH pass cut-through.
        valid_next = ~empty_next & ((pkt_cnt_next != '0) | full_next);
`else
        valid_next = ~empty_next;
`endif
    end

    // Control state: async reset, cleared synchronously by flush via *_next.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b1;
            valid  <= 1'b0;
            empty  <= 1'b1;
`ifdef AXIS_FIFO_PKT_MODE_EN
            pkt_cnt <= '0;
`endif
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            level  <= level_next;
            ready  <= ~full_next;
            valid  <= valid_next;
            empty  <= empty_next;
`ifdef AXIS_FIFO_PKT_MODE_EN
            pkt_cnt <= pkt_cnt_next;
`endif
        end
    end

    // Storage array, not reset; a write coinciding with flush is dropped.
    always_ff @(posedge clk) begin
        if (wr && !flush_i)
            ram[wr_ptr] <= {s_last_i, s_user_i, s_data_i};
    end

endmodule
